// File: rtl/pc_chk_pkg.sv
// Shared types and constants for the PC checker: PC width, FSM states and default
// redirect pipeline depth.
package pc_chk_pkg;

  localparam int PC_W           = 64;
  localparam int PIPE_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } state_t;

endpackage

// File: rtl/pc_chk_satcnt.sv
// CNT_W-bit statistics counter: synchronous clear, increment that sticks at all-ones.
module pc_chk_satcnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (clr)      cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/pc_checker.sv
// Committed-PC vs predicted-PC checker with redirect pulse and statistics.
// Optional capture of the last mismatching pair: define PC_CHECKER_LAST_EN.
module pc_checker
  import pc_chk_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             commit_valid,
  input  logic [PC_W-1:0]  pc_curr,
  input  logic [PC_W-1:0]  pc_pre,
  output logic             miss,
  output logic [PC_W-1:0]  miss_pc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [PC_W-1:0]  last_pre,
  output logic [PC_W-1:0]  last_curr
);

  localparam int DW = $clog2(PIPE_DEPTH + 1);

  state_t        state;
  logic [DW-1:0] dcnt;
  logic          hit_inc, miss_inc, skip_inc;

  // Classify this cycle's commit; commits while not in RUN are never compared.
  always_comb begin
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    skip_inc = 1'b0;
    if (commit_valid) begin
      case (state)
        RUN:     if (pc_pre == pc_curr) hit_inc = 1'b1;
                 else                   miss_inc = 1'b1;
        default: skip_inc = 1'b1;
      endcase
    end
  end

  // Redirect FSM; miss is cleared every cycle unless a new redirect is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dcnt    <= '0;
      miss    <= 1'b0;
      miss_pc <= '0;
    end else begin
      miss <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if ((state == IDLE && commit_valid) || miss_inc) begin
            miss    <= 1'b1;
            miss_pc <= pc_curr;
            dcnt    <= DW'(PIPE_DEPTH);
            state   <= RECOVER;
          end
        end
        RECOVER: begin
          dcnt <= dcnt - DW'(1);
          if (dcnt == DW'(1)) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pc_chk_satcnt #(.CNT_W(CNT_W)) u_hit  (.clk(clk), .clr(rst), .inc(hit_inc),  .cnt(hit_cnt));
  pc_chk_satcnt #(.CNT_W(CNT_W)) u_miss (.clk(clk), .clr(rst), .inc(miss_inc), .cnt(miss_cnt));
  pc_chk_satcnt #(.CNT_W(CNT_W)) u_skip (.clk(clk), .clr(rst), .inc(skip_inc), .cnt(skip_cnt));

`ifdef PC_CHECKER_LAST_EN
  logic [PC_W-1:0] last_pre_q, last_curr_q;

  // Loaded on the same edge that raises miss for a RUN mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_pre_q  <= '0;
      last_curr_q <= '0;
    end else if (miss_inc) begin
      last_pre_q  <= pc_pre;
      last_curr_q <= pc_curr;
    end
  end

  assign last_pre  = last_pre_q;
  assign last_curr = last_curr_q;
`else
  assign last_pre  = '0;
  assign last_curr = '0;
`endif

endmodule

// File: tb/tb_pc_checker.sv
// Self-checking bench for pc_checker: directed scenarios plus randomized traffic
// against a cycle-level behavioural model; a narrow-counter instance covers saturation.
module tb_pc_checker;

  localparam int  PD   = 4;
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;
  localparam int  M_IDLE = 0, M_RUN = 1, M_REC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1, commit_valid = 1'b0;
  logic [63:0] pc_curr = '0, pc_pre = '0;
  logic        miss;
  logic [63:0] miss_pc, last_pre, last_curr;
  logic [31:0] hit_cnt, miss_cnt, skip_cnt;

  logic        s_rst = 1'b1, s_cv = 1'b0;
  logic [63:0] s_cur = '0, s_pre = '0;
  logic        s_miss;
  logic [63:0] s_miss_pc, s_last_pre, s_last_curr;
  logic [1:0]  s_hit, s_mis, s_skip;

  int checks = 0, failures = 0;

  // Behavioural model state
  int          m_mode, m_rem;
  logic        m_miss;
  logic [63:0] m_miss_pc, m_lpre, m_lcur;
  longint      m_hit, m_mis, m_skip;

  always #5 clk = ~clk;

  pc_checker #(.PIPE_DEPTH(PD), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc_curr(pc_curr), .pc_pre(pc_pre),
    .miss(miss), .miss_pc(miss_pc), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .skip_cnt(skip_cnt), .last_pre(last_pre), .last_curr(last_curr));

  pc_checker #(.PIPE_DEPTH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(s_rst), .commit_valid(s_cv), .pc_curr(s_cur), .pc_pre(s_pre),
    .miss(s_miss), .miss_pc(s_miss_pc), .hit_cnt(s_hit), .miss_cnt(s_mis),
    .skip_cnt(s_skip), .last_pre(s_last_pre), .last_curr(s_last_curr));

  function automatic longint sat(input longint v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  task automatic model_step(input logic r, input logic cv, input logic [63:0] cur, input logic [63:0] pre);
    if (r) begin
      m_mode = M_IDLE; m_rem = 0; m_miss = 1'b0; m_miss_pc = '0;
      m_hit = 0; m_mis = 0; m_skip = 0; m_lpre = '0; m_lcur = '0;
      return;
    end
    m_miss = 1'b0;
    if (m_mode == M_REC) begin
      if (cv) m_skip = sat(m_skip);
      m_rem = m_rem - 1;
      if (m_rem == 0) m_mode = M_RUN;
    end else if (cv && (m_mode == M_IDLE || pre != cur)) begin
      if (m_mode == M_IDLE) m_skip = sat(m_skip);
      else begin
        m_mis = sat(m_mis);
`ifdef PC_CHECKER_LAST_EN
        m_lpre = pre; m_lcur = cur;
`endif
      end
      m_miss = 1'b1; m_miss_pc = cur; m_mode = M_REC; m_rem = PD;
    end else if (cv) begin
      m_hit = sat(m_hit);
    end
  endtask

  task automatic step(input logic r, input logic cv, input logic [63:0] cur, input logic [63:0] pre);
    rst = r; commit_valid = cv; pc_curr = cur; pc_pre = pre;
    @(posedge clk);
    model_step(r, cv, cur, pre);
    #1;
    rst = 1'b0; commit_valid = 1'b0;
  endtask

  task automatic step_sat(input logic r, input logic cv, input logic [63:0] cur, input logic [63:0] pre);
    s_rst = r; s_cv = cv; s_cur = cur; s_pre = pre;
    @(posedge clk); #1;
    s_rst = 1'b0; s_cv = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    step(1'b1, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    checks++;
    if ({miss, miss_pc, hit_cnt, miss_cnt, skip_cnt, last_pre, last_curr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got miss=%b miss_pc=%h hit=%0d miss_cnt=%0d skip=%0d lp=%h lc=%h, want all 0",
               miss, miss_pc, hit_cnt, miss_cnt, skip_cnt, last_pre, last_curr);
    end
  endtask

  task automatic test_idle_commit();
    step(1'b0, 1'b1, 64'h1000, 64'h5555);
    checks++;
    if (miss !== 1'b1 || miss_pc !== 64'h1000 || skip_cnt !== 32'd1) begin
      failures++;
      $display("FAIL idle_commit: got miss=%b miss_pc=%h skip=%0d, want 1 1000 1", miss, miss_pc, skip_cnt);
    end
    for (int i = 0; i < PD; i++) begin
      step(1'b0, 1'b0, '0, '0);
      checks++;
      if (miss !== 1'b0 || miss_pc !== 64'h1000) begin
        failures++;
        $display("FAIL idle_hold[%0d]: got miss=%b miss_pc=%h, want 0 1000", i, miss, miss_pc);
      end
    end
  endtask

  task automatic test_hits();
    logic [63:0] pcs [3];
    pcs[0] = 64'h1004; pcs[1] = 64'h1008; pcs[2] = 64'h100C;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, pcs[i], pcs[i]);
      checks++;
      if (miss !== 1'b0) begin
        failures++;
        $display("FAIL hit_no_miss[%0d]: got miss=%b, want 0", i, miss);
      end
    end
    checks++;
    if (hit_cnt !== 32'd3 || miss_cnt !== 32'd0) begin
      failures++;
      $display("FAIL hit_count: got hit=%0d miss_cnt=%0d, want 3 0", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_mismatch();
    step(1'b0, 1'b1, 64'h3000, 64'h2000);
    checks++;
    if (miss !== 1'b1 || miss_pc !== 64'h3000 || miss_cnt !== 32'd1) begin
      failures++;
      $display("FAIL mismatch: got miss=%b miss_pc=%h miss_cnt=%0d, want 1 3000 1", miss, miss_pc, miss_cnt);
    end
    checks++;
    if (last_pre !== m_lpre || last_curr !== m_lcur) begin
      failures++;
      $display("FAIL last_capture: got lp=%h lc=%h, want lp=%h lc=%h", last_pre, last_curr, m_lpre, m_lcur);
    end
  endtask

  task automatic test_recover_skip();
    longint skip0;
    skip0 = m_skip;
    for (int i = 0; i < PD; i++) begin
      step(1'b0, 1'b1, 64'hA000 + 64'(i), 64'hB000);
      checks++;
      if (miss !== 1'b0) begin
        failures++;
        $display("FAIL recover_no_miss[%0d]: got miss=%b, want 0", i, miss);
      end
    end
    checks++;
    if (skip_cnt !== 32'(skip0 + PD) || miss_cnt !== 32'd1) begin
      failures++;
      $display("FAIL recover_skip: got skip=%0d miss_cnt=%0d, want %0d 1", skip_cnt, miss_cnt, skip0 + PD);
    end
    // Back in RUN: a mismatch right away must redirect again, differing only in bit 63.
    step(1'b0, 1'b1, 64'h8000_0000_0000_4000, 64'h4000);
    checks++;
    if (miss !== 1'b1 || miss_pc !== 64'h8000_0000_0000_4000 || miss_cnt !== 32'd2) begin
      failures++;
      $display("FAIL run_after_recover: got miss=%b miss_pc=%h miss_cnt=%0d, want 1 8000000000004000 2",
               miss, miss_pc, miss_cnt);
    end
  endtask

  task automatic test_reset_in_recover();
    step(1'b0, 1'b1, 64'hC000, 64'hC004);
    step(1'b1, 1'b1, 64'hC008, 64'hC00C);
    checks++;
    if ({miss, miss_pc, hit_cnt, miss_cnt, skip_cnt, last_pre, last_curr} !== '0) begin
      failures++;
      $display("FAIL reset_in_recover: got miss=%b miss_pc=%h hit=%0d miss_cnt=%0d skip=%0d lp=%h lc=%h, want all 0",
               miss, miss_pc, hit_cnt, miss_cnt, skip_cnt, last_pre, last_curr);
    end
    step(1'b0, 1'b1, 64'hD000, 64'hD000);
    checks++;
    if (miss !== 1'b1 || miss_pc !== 64'hD000 || skip_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      failures++;
      $display("FAIL commit_after_reset: got miss=%b miss_pc=%h skip=%0d hit=%0d, want 1 d000 1 0",
               miss, miss_pc, skip_cnt, hit_cnt);
    end
  endtask

  task automatic test_random();
    logic        r, cv, prev_miss;
    logic [63:0] cur, pre;
    prev_miss = miss;
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(59, 0) == 0);
      cv  = ($urandom_range(9, 0) < 7);
      cur = {$urandom, $urandom};
      case ($urandom_range(3, 0))
        0, 1:    pre = cur;
        2:       pre = cur ^ (64'd1 << $urandom_range(63, 0));
        default: pre = {$urandom, $urandom};
      endcase
      step(r, cv, cur, pre);
      checks++;
      if (miss !== m_miss || miss_pc !== m_miss_pc) begin
        failures++;
        $display("FAIL rand_miss[%0d]: got %b/%h, want %b/%h", n, miss, miss_pc, m_miss, m_miss_pc);
      end
      checks++;
      if (hit_cnt !== 32'(m_hit) || miss_cnt !== 32'(m_mis) || skip_cnt !== 32'(m_skip)) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: got h=%0d m=%0d s=%0d, want h=%0d m=%0d s=%0d",
                 n, hit_cnt, miss_cnt, skip_cnt, m_hit, m_mis, m_skip);
      end
      checks++;
      if (last_pre !== m_lpre || last_curr !== m_lcur) begin
        failures++;
        $display("FAIL rand_last[%0d]: got %h/%h, want %h/%h", n, last_pre, last_curr, m_lpre, m_lcur);
      end
      checks++;
      if (prev_miss === 1'b1 && miss === 1'b1) begin
        failures++;
        $display("FAIL rand_pulse[%0d]: got miss high two cycles, want single-cycle pulse", n);
      end
      prev_miss = miss;
    end
  endtask

  task automatic test_saturation();
    step_sat(1'b1, 1'b0, '0, '0);
    step_sat(1'b0, 1'b1, 64'h1000, 64'h0);
    step_sat(1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      step_sat(1'b0, 1'b1, 64'h2000 + 64'(4 * i), 64'h2000 + 64'(4 * i));
      checks++;
      if (s_hit !== 2'((i < 3) ? i : 3)) begin
        failures++;
        $display("FAIL sat_hit[%0d]: got %0d, want %0d", i, s_hit, (i < 3) ? i : 3);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      step_sat(1'b0, 1'b1, 64'h9000, 64'h9001);
      step_sat(1'b0, 1'b1, 64'h9100, 64'h9200);
      checks++;
      if (s_mis !== 2'((i < 3) ? i : 3) || s_skip !== 2'((i + 1 < 3) ? i + 1 : 3) || s_hit !== 2'd3) begin
        failures++;
        $display("FAIL sat_miss_skip[%0d]: got m=%0d s=%0d h=%0d, want m=%0d s=%0d h=3",
                 i, s_mis, s_skip, s_hit, (i < 3) ? i : 3, (i + 1 < 3) ? i + 1 : 3);
      end
    end
  endtask

  initial begin
    model_step(1'b1, 1'b0, '0, '0);
    test_reset();
    test_idle_commit();
    test_hits();
    test_mismatch();
    test_recover_skip();
    test_reset_in_recover();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_checker.md
PC_CHECKER -- requirements
Module: pc_checker

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 4: cycles from miss to the first corrected pc_pre.
REQ-002 SHALL have parameter CNT_W, default 32: width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port commit_valid, input, 1: pc_curr holds a committed PC this cycle.
REQ-006 SHALL have port pc_curr, input, 64: actual committed PC from the simulator interface.
REQ-007 SHALL have port pc_pre, input, 64: predicted PC from the predictor stage.
REQ-008 SHALL have port miss, output, 1: registered redirect pulse to the predictor.
REQ-009 SHALL have port miss_pc, output, 64: registered PC for the predictor to resync on, valid while miss=1.
REQ-010 SHALL have ports hit_cnt, miss_cnt and skip_cnt, output, CNT_W each: statistics.
REQ-011 SHALL have ports last_pre and last_curr, output, 64 each: capture of the last mismatching PC pair.

Function
REQ-012 SHALL implement states IDLE, RUN and RECOVER, with state and count held in registers.
REQ-013 IDLE: on commit_valid, SHALL next cycle set miss=1, set miss_pc=pc_curr, increment skip_cnt and go to RECOVER; otherwise SHALL stay in IDLE.
REQ-014 RUN, commit_valid with pc_pre==pc_curr: SHALL increment hit_cnt, keep miss=0 and stay in RUN.
REQ-015 RUN, commit_valid with pc_pre!=pc_curr: SHALL next cycle set miss=1, set miss_pc=pc_curr, increment miss_cnt and go to RECOVER.
REQ-016 RUN without commit_valid: SHALL change no state and no counter.
REQ-017 miss SHALL be a one-cycle pulse and SHALL never be high on two consecutive cycles.
REQ-018 On entering RECOVER, the down-counter SHALL load PIPE_DEPTH.
REQ-019 RECOVER: the down-counter SHALL decrement every cycle, and the FSM SHALL go to RUN the cycle after it reads 1.
REQ-020 RECOVER: every commit_valid SHALL increment skip_cnt and SHALL NOT compare PCs, including on the final RECOVER cycle.
REQ-021 Counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-022 The PC compare SHALL use the full 64 bits, with no masking of the low bits.
REQ-023 miss_pc SHALL hold its value after miss deasserts.

Reset
REQ-024 rst SHALL dominate every other input in the same cycle.
REQ-025 rst SHALL force state=IDLE, down-counter=0, miss=0, miss_pc=0, all counters=0 and last_pre=last_curr=0.
REQ-026 A rst during RECOVER SHALL abandon the countdown, and the next commit SHALL be handled as in IDLE.

Configuration
REQ-027 With PC_CHECKER_LAST_EN defined, each RUN mismatch SHALL load last_pre=pc_pre and last_curr=pc_curr in the same cycle that miss is registered.
REQ-028 Without PC_CHECKER_LAST_EN, last_pre and last_curr SHALL be constant 0 and no capture registers SHALL exist.

Structure
REQ-029 Package pc_chk_pkg SHALL hold PC_W=64, the state enum (IDLE/RUN/RECOVER) and the default PIPE_DEPTH.
REQ-030 Sub-module pc_chk_satcnt (CNT_W-bit saturating counter: inc, clr) SHALL be instantiated three times.

Verification
REQ-031 rst, then commit_valid with pc_curr=0x1000 -> next cycle miss=1, miss_pc=0x1000, skip_cnt=1, state=RECOVER.
REQ-032 In RUN, three commits with pc_pre==pc_curr (0x1004, 0x1008, 0x100C) -> hit_cnt=3, miss never 1.
REQ-033 In RUN, pc_pre=0x2000 with pc_curr=0x3000 -> miss pulse, miss_pc=0x3000, miss_cnt=1; last_curr=0x3000 only with PC_CHECKER_LAST_EN.
REQ-034 Commits on every RECOVER cycle with mismatched PCs -> skip_cnt increments by PIPE_DEPTH, no miss, RUN after PIPE_DEPTH cycles.
REQ-035 rst asserted on the second RECOVER cycle -> all outputs 0 and state=IDLE the next cycle.
REQ-036 hit_cnt forced to 0xFFFFFFFE, then three hits -> hit_cnt=0xFFFFFFFF.
